led_pattern_decoder: RTL and testbench
======================================

LED_PATTERN_DECODER -- requirements
Module: led_pattern_decoder

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 8 (2..15): consecutive identical per-cycle classes required to lock.
REQ-002 SHALL have parameter MISS_MAX, default 2 (0..7): consecutive mismatches tolerated while locked.
REQ-003 SHALL have port clk_pll  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  decoding enable; low forces IDLE.
REQ-006 SHALL have port led_in  input  8  LED bus sampled from the pattern generator, synchronous to clk_pll.
REQ-007 SHALL have port pattern_id  output  5  identified pattern number; 31 = unknown.
REQ-008 SHALL have port locked  output  1  high while a pattern is identified.
REQ-009 SHALL have port id_strobe  output  1  one-cycle pulse on lock acquisition.
REQ-010 SHALL have port lock_lost  output  1  one-cycle pulse on lock loss.

Function
REQ-011 SHALL register the previous sample prev; class is computed from (prev, led_in) only when prev_valid=1.
REQ-012 SHALL classify in this priority: 0 if prev=cur=00; 1 if prev=cur=FF; 2 if {prev,cur} is {FF,00} or {00,FF}; 4 if {prev,cur} is {AA,55} or {55,AA}; 3 if prev and cur are one-hot and cur=rotl1(prev); 5 if ~prev and ~cur are one-hot and ~cur=rotl1(~prev); 13 if cur=prev+1 mod 256 (wraps FF->00); else 31.
REQ-013 SHALL implement states IDLE, ACQUIRE, LOCKED; enable=0 forces IDLE from any state on the next edge.
REQ-014 IDLE: prev_valid=0, cand=31, run=0, miss=0, pattern_id=31, locked=0; an edge with enable=1 loads prev, sets prev_valid, goes to ACQUIRE.
REQ-015 ACQUIRE: class 31 -> run=0; class=cand -> run+1; else cand=class, run=1.
REQ-016 ACQUIRE: the edge on which run reaches LOCK_CNT SHALL enter LOCKED, pattern_id=cand, locked=1, id_strobe=1 for that cycle.
REQ-017 LOCKED: class=pattern_id -> miss=0; else miss+1.
REQ-018 LOCKED: the edge producing the (MISS_MAX+1)th consecutive mismatch SHALL enter ACQUIRE, locked=0, pattern_id=31, lock_lost=1 for one cycle, cand=31, run=0, miss=0.
REQ-019 With a constant valid pattern from enable rise, locked SHALL rise on the (LOCK_CNT+1)th rising edge with enable high.
REQ-020 id_strobe and lock_lost SHALL never assert in the same cycle; neither asserts in IDLE.
REQ-021 Run and miss counters SHALL saturate and never wrap.

Reset
REQ-022 rstn low SHALL asynchronously force IDLE, pattern_id=31, locked=0, id_strobe=0, lock_lost=0, prev=00, prev_valid=0, run=0, miss=0.
REQ-023 Reset release mid-pattern SHALL restart acquisition from IDLE; no pulse is generated by the reset itself.

Structure
REQ-024 SHALL place pattern ID constants (0,1,2,3,4,5,13), ID_UNKNOWN=31 and state encodings in shared package led_pattern_pkg.
REQ-025 SHALL implement the REQ-012 classifier as combinational sub-module led_pattern_classify (prev, cur -> class).

Verification
REQ-026 Reset, enable=1, led_in=00 constant -> locked and id_strobe on 9th edge, pattern_id=0, id_strobe then low.
REQ-027 led_in alternating FF/00 -> pattern_id=2; alternating AA/55 -> pattern_id=4.
REQ-028 led_in 01,02,04,...,80,01 rotating -> pattern_id=3 (not 13); led_in incrementing 10,11,12,... through FF->00 -> pattern_id=13, lock held across wrap.
REQ-029 Locked on 0, one 5A sample inserted (2 mismatches) -> locked stays 1; two 5A samples (3 mismatches) -> lock_lost pulse, locked=0, pattern_id=31, relock to 0 after 8 classes.
REQ-030 enable dropped after 5 matching classes in ACQUIRE -> IDLE, no id_strobe; re-enable needs full 9 edges.
REQ-031 rstn asserted asynchronously while locked -> outputs at reset values immediately, no lock_lost pulse.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern decoder.
// Holds the pattern ID constants, the decoder state encoding and small
// bit-manipulation helpers used by the classifier.
package led_pattern_pkg;

  localparam logic [4:0] ID_ZEROS   = 5'd0;   // 00 -> 00
  localparam logic [4:0] ID_ONES    = 5'd1;   // FF -> FF
  localparam logic [4:0] ID_TOGGLE  = 5'd2;   // FF <-> 00
  localparam logic [4:0] ID_WALK1   = 5'd3;   // walking one, rotate left
  localparam logic [4:0] ID_ALT     = 5'd4;   // AA <-> 55
  localparam logic [4:0] ID_WALK0   = 5'd5;   // walking zero, rotate left
  localparam logic [4:0] ID_COUNT   = 5'd13;  // binary up-counter
  localparam logic [4:0] ID_UNKNOWN = 5'd31;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2
  } state_e;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

endpackage

// File: rtl/led_pattern_classify.sv
// Combinational per-cycle classifier for the LED pattern decoder.
// Maps a (previous, current) LED sample pair to a pattern ID; the checks are
// evaluated in priority order so overlapping pairs (e.g. FF->00, which is also
// an increment) resolve to the higher-priority pattern.
// Ports:
//   prev_i  - previous LED sample
//   cur_i   - current LED sample
//   class_o - pattern ID of this pair, ID_UNKNOWN if none matches
module led_pattern_classify
  import led_pattern_pkg::*;
(
  input  logic [7:0] prev_i,
  input  logic [7:0] cur_i,
  output logic [4:0] class_o
);

  logic [7:0] prev_n;
  logic [7:0] cur_n;

  assign prev_n = ~prev_i;
  assign cur_n  = ~cur_i;

  always_comb begin
    class_o = ID_UNKNOWN;
    if (prev_i == 8'h00 && cur_i == 8'h00) begin
      class_o = ID_ZEROS;
    end else if (prev_i == 8'hFF && cur_i == 8'hFF) begin
      class_o = ID_ONES;
    end else if ((prev_i == 8'hFF && cur_i == 8'h00) || (prev_i == 8'h00 && cur_i == 8'hFF)) begin
      class_o = ID_TOGGLE;
    end else if ((prev_i == 8'hAA && cur_i == 8'h55) || (prev_i == 8'h55 && cur_i == 8'hAA)) begin
      class_o = ID_ALT;
    end else if (is_onehot(prev_i) && is_onehot(cur_i) && cur_i == rotl1(prev_i)) begin
      class_o = ID_WALK1;
    end else if (is_onehot(prev_n) && is_onehot(cur_n) && cur_n == rotl1(prev_n)) begin
      class_o = ID_WALK0;
    end else if (cur_i == prev_i + 8'd1) begin
      class_o = ID_COUNT;
    end
  end

endmodule

// File: rtl/led_pattern_decoder.sv
// LED pattern decoder: identifies which repeating pattern a generator is
// driving onto an 8-bit LED bus. Each cycle the (prev, cur) pair is
// classified; LOCK_CNT identical consecutive classes acquire lock, and more
// than MISS_MAX consecutive mismatches while locked drop it again.
// Ports:
//   clk_pll    - clock, all state on rising edge
//   rstn       - asynchronous active-low reset
//   enable     - decoding enable; low returns to idle on the next edge
//   led_in     - sampled LED bus
//   pattern_id - identified pattern, 31 when unknown
//   locked     - high while a pattern is identified
//   id_strobe  - one-cycle pulse on lock acquisition
//   lock_lost  - one-cycle pulse on lock loss
module led_pattern_decoder
  import led_pattern_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned MISS_MAX = 2
) (
  input  logic       clk_pll,
  input  logic       rstn,
  input  logic       enable,
  input  logic [7:0] led_in,
  output logic [4:0] pattern_id,
  output logic       locked,
  output logic       id_strobe,
  output logic       lock_lost
);

  localparam logic [3:0] LockCntM1 = 4'(LOCK_CNT - 1);
  localparam logic [2:0] MissMax   = 3'(MISS_MAX);

  state_e     state_q, state_d;
  logic [7:0] prev_q, prev_d;
  logic       prev_valid_q, prev_valid_d;
  logic [4:0] cand_q, cand_d;
  logic [3:0] run_q, run_d;
  logic [2:0] miss_q, miss_d;
  logic [4:0] pattern_id_q, pattern_id_d;
  logic       id_strobe_q, id_strobe_d;
  logic       lock_lost_q, lock_lost_d;

  logic [4:0] cls_raw;
  logic [4:0] cls;

  led_pattern_classify u_classify (
    .prev_i  (prev_q),
    .cur_i   (led_in),
    .class_o (cls_raw)
  );

  // Without a valid previous sample there is no pair to classify.
  assign cls = prev_valid_q ? cls_raw : ID_UNKNOWN;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    cand_d       = cand_q;
    run_d        = run_q;
    miss_d       = miss_q;
    pattern_id_d = pattern_id_q;
    id_strobe_d  = 1'b0;
    lock_lost_d  = 1'b0;

    if (!enable) begin
      state_d      = StIdle;
      prev_d       = 8'h00;
      prev_valid_d = 1'b0;
      cand_d       = ID_UNKNOWN;
      run_d        = 4'd0;
      miss_d       = 3'd0;
      pattern_id_d = ID_UNKNOWN;
    end else begin
      unique case (state_q)
        StIdle: begin
          prev_d       = led_in;
          prev_valid_d = 1'b1;
          state_d      = StAcquire;
        end

        StAcquire: begin
          prev_d = led_in;
          if (cls == ID_UNKNOWN) begin
            run_d = 4'd0;
          end else if (cls == cand_q) begin
            if (run_q >= LockCntM1) begin
              state_d      = StLocked;
              pattern_id_d = cand_q;
              id_strobe_d  = 1'b1;
              run_d        = 4'd0;
              miss_d       = 3'd0;
            end else begin
              run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
            end
          end else begin
            cand_d = cls;
            run_d  = 4'd1;
          end
        end

        StLocked: begin
          prev_d = led_in;
          if (cls == pattern_id_q) begin
            miss_d = 3'd0;
          end else if (miss_q >= MissMax) begin
            // This mismatch is one beyond the tolerance: drop lock.
            state_d      = StAcquire;
            pattern_id_d = ID_UNKNOWN;
            lock_lost_d  = 1'b1;
            cand_d       = ID_UNKNOWN;
            run_d        = 4'd0;
            miss_d       = 3'd0;
          end else begin
            miss_d = (miss_q == 3'h7) ? miss_q : miss_q + 3'd1;
          end
        end

        default: begin
          state_d      = StIdle;
          prev_valid_d = 1'b0;
          pattern_id_d = ID_UNKNOWN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pll or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      prev_q       <= 8'h00;
      prev_valid_q <= 1'b0;
      cand_q       <= ID_UNKNOWN;
      run_q        <= 4'd0;
      miss_q       <= 3'd0;
      pattern_id_q <= ID_UNKNOWN;
      id_strobe_q  <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      cand_q       <= cand_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      pattern_id_q <= pattern_id_d;
      id_strobe_q  <= id_strobe_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign pattern_id = pattern_id_q;
  assign locked     = (state_q == StLocked);
  assign id_strobe  = id_strobe_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_led_pattern_decoder.sv
module tb_led_pattern_decoder;

  logic       clk_pll = 1'b0;
  logic       rstn;
  logic       enable;
  logic [7:0] led_in;
  logic [4:0] pattern_id;
  logic       locked;
  logic       id_strobe;
  logic       lock_lost;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] seq_v;
  int         lost_seen;
  int         strobe_seen;
  int         both_seen;

  led_pattern_decoder u_dut (
    .clk_pll    (clk_pll),
    .rstn       (rstn),
    .enable     (enable),
    .led_in     (led_in),
    .pattern_id (pattern_id),
    .locked     (locked),
    .id_strobe  (id_strobe),
    .lock_lost  (lock_lost)
  );

  always #5 clk_pll = ~clk_pll;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, take one rising edge, sample outputs 1 ns later.
  task automatic step(input logic [7:0] v);
    led_in = v;
    @(posedge clk_pll);
    #1;
    if (lock_lost) lost_seen++;
    if (id_strobe) strobe_seen++;
    if (lock_lost && id_strobe) both_seen++;
  endtask

  // mode 0: invert each cycle; mode 1: rotate left; mode 2: increment.
  task automatic run_seq(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      step(seq_v);
      case (mode)
        0: seq_v = ~seq_v;
        1: seq_v = {seq_v[6:0], seq_v[7]};
        default: seq_v = seq_v + 8'd1;
      endcase
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    step(8'h00);
    check("idle_locked", int'(locked), 0);
    check("idle_pid", int'(pattern_id), 31);
    enable = 1'b1;
  endtask

  initial begin
    rstn      = 1'b1;
    enable    = 1'b0;
    led_in    = 8'h00;
    lost_seen = 0;
    strobe_seen = 0;
    both_seen = 0;
    #1 rstn = 1'b0;
    #1;
    check("rst_pid", int'(pattern_id), 31);
    check("rst_locked", int'(locked), 0);
    check("rst_strobe", int'(id_strobe), 0);
    check("rst_lost", int'(lock_lost), 0);
    step(8'h00);
    step(8'h00);
    rstn   = 1'b1;
    enable = 1'b1;

    // Constant 00: lock on the 9th edge.
    strobe_seen = 0;
    for (int i = 0; i < 8; i++) step(8'h00);
    check("zeros_early_lock", int'(locked), 0);
    check("zeros_early_strobe", strobe_seen, 0);
    step(8'h00);
    check("zeros_locked", int'(locked), 1);
    check("zeros_strobe", int'(id_strobe), 1);
    check("zeros_pid", int'(pattern_id), 0);
    step(8'h00);
    check("zeros_strobe_low", int'(id_strobe), 0);
    check("zeros_still_locked", int'(locked), 1);

    // One 5A sample: two mismatches, tolerated.
    lost_seen = 0;
    step(8'h5A);
    step(8'h00);
    check("miss2_locked", int'(locked), 1);
    step(8'h00);
    check("miss2_no_lost", lost_seen, 0);
    // Two 5A samples: third mismatch drops lock.
    step(8'h5A);
    step(8'h5A);
    check("miss3_before", int'(locked), 1);
    step(8'h00);
    check("miss3_lost", int'(lock_lost), 1);
    check("miss3_locked", int'(locked), 0);
    check("miss3_pid", int'(pattern_id), 31);
    step(8'h00);
    check("miss3_lost_pulse", int'(lock_lost), 0);
    for (int i = 0; i < 6; i++) step(8'h00);
    check("relock_early", int'(locked), 0);
    step(8'h00);
    check("relock_locked", int'(locked), 1);
    check("relock_strobe", int'(id_strobe), 1);
    check("relock_pid", int'(pattern_id), 0);

    // FF/00 toggling.
    go_idle();
    seq_v = 8'hFF;
    run_seq(0, 8);
    check("toggle_early", int'(locked), 0);
    run_seq(0, 1);
    check("toggle_locked", int'(locked), 1);
    check("toggle_pid", int'(pattern_id), 2);

    // AA/55 alternating.
    go_idle();
    seq_v = 8'hAA;
    run_seq(0, 9);
    check("alt_locked", int'(locked), 1);
    check("alt_pid", int'(pattern_id), 4);

    // Walking one, through the 80 -> 01 wrap.
    go_idle();
    seq_v = 8'h01;
    run_seq(1, 9);
    check("walk1_pid", int'(pattern_id), 3);
    lost_seen = 0;
    run_seq(1, 10);
    check("walk1_wrap_locked", int'(locked), 1);
    check("walk1_wrap_lost", lost_seen, 0);

    // Walking zero.
    go_idle();
    seq_v = 8'hFE;
    run_seq(1, 9);
    check("walk0_locked", int'(locked), 1);
    check("walk0_pid", int'(pattern_id), 5);

    // Counter from 10, held across FF -> 00.
    go_idle();
    seq_v = 8'h10;
    run_seq(2, 9);
    check("count_locked", int'(locked), 1);
    check("count_pid", int'(pattern_id), 13);
    lost_seen = 0;
    run_seq(2, 240);
    check("count_wrap_locked", int'(locked), 1);
    check("count_wrap_pid", int'(pattern_id), 13);
    check("count_wrap_lost", lost_seen, 0);

    // Enable dropped after 5 matching classes.
    go_idle();
    strobe_seen = 0;
    for (int i = 0; i < 6; i++) step(8'h00);
    enable = 1'b0;
    step(8'h00);
    check("en_drop_locked", int'(locked), 0);
    check("en_drop_strobe", strobe_seen, 0);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) step(8'h00);
    check("reen_early", int'(locked), 0);
    check("reen_strobe_none", strobe_seen, 0);
    step(8'h00);
    check("reen_locked", int'(locked), 1);
    check("reen_strobe", int'(id_strobe), 1);

    // Asynchronous reset while locked.
    step(8'h00);
    lost_seen = 0;
    #2 rstn = 1'b0;
    #1;
    check("arst_locked", int'(locked), 0);
    check("arst_pid", int'(pattern_id), 31);
    check("arst_strobe", int'(id_strobe), 0);
    step(8'h00);
    step(8'h00);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) step(8'h00);
    check("arst_no_lost", lost_seen, 0);
    check("arst_relock_early", int'(locked), 0);
    step(8'h00);
    check("arst_relock", int'(locked), 1);

    check("never_both_pulses", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
